// File: rtl/button_press_gen_pkg.sv
// Shared state encodings, default widths and helpers for the button
// waveform generator.
package button_press_gen_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_B_PRESS = 3'd1,
      S_PRESS   = 3'd2,
      S_B_REL   = 3'd3,
      S_GAP     = 3'd4
   } state_t;

   localparam int CNT_W_DEF      = 16;
   localparam int BOUNCE_N_DEF   = 3;
   localparam int BOUNCE_LEN_DEF = 2;

   function automatic logic [7:0] nz8(input logic [7:0] v);
      return (v == 8'd0) ? 8'd1 : v;
   endfunction

endpackage

// File: rtl/button_press_gen_timer.sv
// cycle_timer: loadable down-counter that parks at zero and flags it.
// Used for every phase duration of the button generator.
module cycle_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/button_press_gen.sv
// Button waveform generator: press/hold/release/gap bursts from a command.
// Define BUTTON_BOUNCE_EN to emit contact-bounce pulses before each edge.
import button_press_gen_pkg::*;

module button_press_gen #(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int BOUNCE_N   = BOUNCE_N_DEF,
   parameter int BOUNCE_LEN = BOUNCE_LEN_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] press_len,
   input  logic [CNT_W-1:0] gap_len,
   input  logic [7:0]       repeat_cnt,
   output logic             button,
   output logic             busy,
   output logic             done,
   output logic [7:0]       press_cnt
);

   state_t           r_state;
   logic             r_pend;
   logic [CNT_W-1:0] r_press_m1;
   logic [CNT_W-1:0] r_gap_m1;
   logic [7:0]       r_rep;
   logic             r_button;
   logic             r_busy;
   logic             r_done;
   logic [7:0]       r_press_cnt;

   logic             w_load;
   logic [CNT_W-1:0] w_val;
   logic             w_zero;
   logic             w_more;

   assign w_more = (r_press_cnt < r_rep);

`ifdef BUTTON_BOUNCE_EN
   localparam logic [CNT_W-1:0] BL_M1    = CNT_W'(BOUNCE_LEN - 1);
   localparam logic [7:0]       TOG_LAST = 8'(2 * BOUNCE_N - 1);

   logic [7:0] r_tog;
   logic       w_last;

   assign w_last = (r_tog == TOG_LAST);
`else
   localparam int UNUSED_B = BOUNCE_N + BOUNCE_LEN;
`endif

   cycle_timer #(
      .W(CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_val  (w_val),
      .o_zero (w_zero)
   );

   // Timer reloads coincide with the FSM transitions below.
   always_comb begin
      w_load = 1'b0;
      w_val  = r_press_m1;
      unique case (r_state)
         S_IDLE: begin
            if (r_pend) begin
               w_load = 1'b1;
`ifdef BUTTON_BOUNCE_EN
               w_val  = BL_M1;
`else
               w_val  = r_press_m1;
`endif
            end
         end
         S_PRESS: begin
            if (w_zero) begin
               w_load = 1'b1;
`ifdef BUTTON_BOUNCE_EN
               w_val  = BL_M1;
`else
               w_val  = r_gap_m1;
`endif
            end
         end
         S_GAP: begin
            if (w_zero && w_more) begin
               w_load = 1'b1;
`ifdef BUTTON_BOUNCE_EN
               w_val  = BL_M1;
`else
               w_val  = r_press_m1;
`endif
            end
         end
`ifdef BUTTON_BOUNCE_EN
         S_B_PRESS: begin
            if (w_zero) begin
               w_load = 1'b1;
               w_val  = w_last ? r_press_m1 : BL_M1;
            end
         end
         S_B_REL: begin
            if (w_zero) begin
               w_load = 1'b1;
               w_val  = w_last ? r_gap_m1 : BL_M1;
            end
         end
`endif
         default: begin
            w_load = 1'b0;
         end
      endcase
   end

   // A start is latched first; the burst begins on the following edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_pend      <= 1'b0;
         r_press_m1  <= '0;
         r_gap_m1    <= '0;
         r_rep       <= 8'd1;
         r_button    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_press_cnt <= 8'd0;
`ifdef BUTTON_BOUNCE_EN
         r_tog       <= 8'd0;
`endif
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (r_pend) begin
                  r_pend   <= 1'b0;
                  r_busy   <= 1'b1;
                  r_button <= 1'b1;
`ifdef BUTTON_BOUNCE_EN
                  r_state  <= S_B_PRESS;
                  r_tog    <= 8'd0;
`else
                  r_state     <= S_PRESS;
                  r_press_cnt <= r_press_cnt + 8'd1;
`endif
               end else if (start) begin
                  r_pend      <= 1'b1;
                  r_press_cnt <= 8'd0;
                  r_rep       <= nz8(repeat_cnt);
                  r_press_m1  <= (press_len == '0) ? '0
                                 : press_len - 1'b1;
                  r_gap_m1    <= (gap_len == '0) ? '0
                                 : gap_len - 1'b1;
               end
            end
            S_PRESS: begin
               if (w_zero) begin
                  r_button <= 1'b0;
`ifdef BUTTON_BOUNCE_EN
                  r_state  <= S_B_REL;
                  r_tog    <= 8'd0;
`else
                  r_state  <= S_GAP;
`endif
               end
            end
            S_GAP: begin
               if (w_zero) begin
                  if (w_more) begin
                     r_button <= 1'b1;
`ifdef BUTTON_BOUNCE_EN
                     r_state  <= S_B_PRESS;
                     r_tog    <= 8'd0;
`else
                     r_state     <= S_PRESS;
                     r_press_cnt <= r_press_cnt + 8'd1;
`endif
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
`ifdef BUTTON_BOUNCE_EN
            S_B_PRESS: begin
               if (w_zero) begin
                  r_button <= ~r_button;
                  if (w_last) begin
                     r_state     <= S_PRESS;
                     r_press_cnt <= r_press_cnt + 8'd1;
                  end else begin
                     r_tog <= r_tog + 8'd1;
                  end
               end
            end
            S_B_REL: begin
               if (w_zero) begin
                  r_button <= ~r_button;
                  if (w_last) begin
                     r_state <= S_GAP;
                  end else begin
                     r_tog <= r_tog + 8'd1;
                  end
               end
            end
`endif
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign button    = r_button;
   assign busy      = r_busy;
   assign done      = r_done;
   assign press_cnt = r_press_cnt;

endmodule

// File: tb/tb_button_press_gen.sv
// Directed bench for button_press_gen; define BUTTON_BOUNCE_EN to also
// cover the bounce build.
module tb_button_press_gen;

   localparam int CNT_W = 16;
   localparam int BN    = 3;
   localparam int BL    = 2;
`ifdef BUTTON_BOUNCE_EN
   localparam int B     = 2 * BN * BL;
`else
   localparam int B     = 0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] press_len = '0;
   logic [CNT_W-1:0] gap_len = '0;
   logic [7:0]       repeat_cnt = '0;
   logic             button;
   logic             busy;
   logic             done;
   logic [7:0]       press_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   button_press_gen #(
      .CNT_W      (CNT_W),
      .BOUNCE_N   (BN),
      .BOUNCE_LEN (BL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .press_len  (press_len),
      .gap_len    (gap_len),
      .repeat_cnt (repeat_cnt),
      .button     (button),
      .busy       (busy),
      .done       (done),
      .press_cnt  (press_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; issues start then checks every cycle to done.
   task automatic burst(input int tid, input int p, input int g,
                        input int r, input bit poke);
      int pp, gg, rr, per, tot, q, off, eb, ecnt;
      pp  = (p == 0) ? 1 : p;
      gg  = (g == 0) ? 1 : g;
      rr  = (r == 0) ? 1 : r;
      per = B + pp + B + gg;
      tot = rr * per;
      start      = 1'b1;
      press_len  = CNT_W'(p);
      gap_len    = CNT_W'(g);
      repeat_cnt = 8'(r);
      @(posedge clk);
      @(negedge clk);
      start      = 1'b0;
      press_len  = 16'd40;
      gap_len    = 16'd40;
      repeat_cnt = 8'd9;
      chk($sformatf("t%0d e0 busy", tid), 32'(busy), 0);
      chk($sformatf("t%0d e0 cnt", tid), 32'(press_cnt), 0);
      for (int k = 1; k <= tot + 1; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (poke && k == 2) start = 1'b1;
         if (poke && k == 3) start = 1'b0;
         q   = (k - 1) / per;
         off = (k - 1) % per;
         if (k <= tot) begin
            if (off < B)                eb = ((off / BL) % 2 == 0) ? 1 : 0;
            else if (off < B + pp)      eb = 1;
            else if (off < 2 * B + pp)  eb = (((off - B - pp) / BL) % 2 == 1) ? 1 : 0;
            else                        eb = 0;
            ecnt = q + ((off >= B) ? 1 : 0);
            chk($sformatf("t%0d k%0d btn", tid, k), 32'(button), 32'(eb));
            chk($sformatf("t%0d k%0d busy", tid, k), 32'(busy), 1);
            chk($sformatf("t%0d k%0d done", tid, k), 32'(done), 0);
            chk($sformatf("t%0d k%0d cnt", tid, k), 32'(press_cnt), 32'(ecnt));
         end else begin
            chk($sformatf("t%0d end btn", tid), 32'(button), 0);
            chk($sformatf("t%0d end busy", tid), 32'(busy), 0);
            chk($sformatf("t%0d end done", tid), 32'(done), 1);
            chk($sformatf("t%0d end cnt", tid), 32'(press_cnt), 32'(rr));
         end
      end
   endtask

   initial begin
      // 1: reset held with start asserted
      start = 1'b1;
      press_len = 16'd5;
      repeat (3) begin
         @(negedge clk);
         chk("rst btn", 32'(button), 0);
         chk("rst busy", 32'(busy), 0);
         chk("rst done", 32'(done), 0);
         chk("rst cnt", 32'(press_cnt), 0);
      end
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post rst busy", 32'(busy), 0);

      // 2: single press, done 9 edges after start
      burst(2, 5, 3, 1, 1'b0);
      chk("t2 cnt hand", 32'(press_cnt), 1);

      // 3: back-to-back burst, mid-burst start ignored
      burst(3, 2, 2, 3, 1'b1);
      @(negedge clk);
      chk("t3 done pulse", 32'(done), 0);
      chk("t3 cnt hold", 32'(press_cnt), 3);

      // 5: async reset while button high
      start      = 1'b1;
      press_len  = 16'd2;
      gap_len    = 16'd2;
      repeat_cnt = 8'd3;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("t5 pre btn", 32'(button), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t5 async btn", 32'(button), 0);
      chk("t5 async busy", 32'(busy), 0);
      chk("t5 async cnt", 32'(press_cnt), 0);
      chk("t5 async done", 32'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 4: zero fields after reset recovery
      burst(4, 0, 0, 0, 1'b0);
      @(negedge clk);
      chk("t4 idle busy", 32'(busy), 0);

`ifdef BUTTON_BOUNCE_EN
      // 6: bounce build, done 33 edges after start
      burst(6, 5, 3, 1, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
